axis_mux_v1: RTL and testbench

N-to-1 AXI4-Stream multiplexer: the companion to the 1-to-N stream switch, merging one of N input streams onto a single output. The active input follows an externally supplied channel select, normally driven from an AXI-Lite config register. Select changes are applied only at packet boundaries, so no packet is ever split across channels. A two-entry output skid buffer keeps full throughput with registered ready and valid outputs.

---
 rtl/axis_mux_v1.sv | 123 ++++++++++++
 tb/tb_axis_mux_v1.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/axis_mux_v1.sv
// N-to-1 AXI4-Stream mux; select is switched only between packets. One cycle of latency.
// A two-entry main/skid buffer gives full rate; the input is stalled only when skid holds a beat.
module axis_mux_v1 #(
    parameter  int B  = 8,
    parameter  int N  = 16,
    localparam int SW = $clog2(N)
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [SW-1:0]   sel,
    output logic [SW-1:0]   act_sel,
    input  logic [N-1:0]    s_axis_tvalid,
    output logic [N-1:0]    s_axis_tready,
    input  logic [N*B-1:0]  s_axis_tdata,
    input  logic [N-1:0]    s_axis_tlast,
    output logic            m_axis_tvalid,
    input  logic            m_axis_tready,
    output logic [B-1:0]    m_axis_tdata,
    output logic            m_axis_tlast
);

    typedef enum logic {IDLE, PKT} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [SW-1:0]   r_act;
    logic            r_en;
    logic            r_m_vld;
    logic [B-1:0]    r_m_dat;
    logic            r_m_last;
    logic            r_s_vld;
    logic [B-1:0]    r_s_dat;
    logic            r_s_last;

    logic            w_in_vld;
    logic [B-1:0]    w_in_dat;
    logic            w_in_last;
    logic            w_acc;
    logic            w_main_free;

    always_comb begin
        w_in_vld  = 1'b0;
        w_in_dat  = '0;
        w_in_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_act == SW'(i)) begin
                w_in_vld  = s_axis_tvalid[i];
                w_in_dat  = s_axis_tdata[i*B +: B];
                w_in_last = s_axis_tlast[i];
            end
        end
    end

    // Ready depends only on registers, so no input reaches any output combinationally.
    assign w_acc       = w_in_vld & r_en & ~r_s_vld;
    assign w_main_free = ~r_m_vld | m_axis_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_acc & ~w_in_last) w_state_nxt = PKT;
            PKT:     if (w_acc &  w_in_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = '0;
        for (int i = 0; i < N; i++) begin
            s_axis_tready[i] = r_en & ~r_s_vld & (r_act == SW'(i));
        end
    end

    // The channel that opens a packet stays granted even if sel moves on the same edge.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_act <= '0;
            r_en  <= 1'b0;
        end else begin
            r_en <= 1'b1;
            if (r_state == IDLE && !(w_acc && !w_in_last)) r_act <= sel;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_m_vld  <= 1'b0;
            r_m_dat  <= '0;
            r_m_last <= 1'b0;
            r_s_vld  <= 1'b0;
            r_s_dat  <= '0;
            r_s_last <= 1'b0;
        end else if (w_main_free) begin
            if (r_s_vld) begin
                r_m_vld  <= 1'b1;
                r_m_dat  <= r_s_dat;
                r_m_last <= r_s_last;
                r_s_vld  <= 1'b0;
            end else if (w_acc) begin
                r_m_vld  <= 1'b1;
                r_m_dat  <= w_in_dat;
                r_m_last <= w_in_last;
            end else begin
                r_m_vld  <= 1'b0;
            end
        end else if (w_acc) begin
            r_s_vld  <= 1'b1;
            r_s_dat  <= w_in_dat;
            r_s_last <= w_in_last;
        end
    end

    assign act_sel       = r_act;
    assign m_axis_tvalid = r_m_vld;
    assign m_axis_tdata  = r_m_dat;
    assign m_axis_tlast  = r_m_last;

endmodule

// File: tb/tb_axis_mux_v1.sv
// Directed bench for axis_mux_v1 with N=16, B=8.
module tb_axis_mux_v1;
    localparam int B  = 8;
    localparam int N  = 16;
    localparam int SW = 4;

    logic            aclk = 1'b0;
    logic            areset = 1'b0;
    logic [SW-1:0]   sel = '0;
    logic [SW-1:0]   act_sel;
    logic [N-1:0]    s_tvalid = '0;
    logic [N-1:0]    s_tready;
    logic [N*B-1:0]  s_tdata = '0;
    logic [N-1:0]    s_tlast = '0;
    logic            m_tvalid;
    logic            m_tready = 1'b0;
    logic [B-1:0]    m_tdata;
    logic            m_tlast;

    int n_chk = 0;
    int n_err = 0;

    axis_mux_v1 #(.B(B), .N(N)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .sel           (sel),
        .act_sel       (act_sel),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .s_axis_tlast  (s_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast)
    );

    always #5 aclk = ~aclk;

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int ch, input logic [7:0] d, input logic l);
        s_tdata[ch*B +: B] = d;
        s_tlast[ch]        = l;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] din [100];
    bit         patt [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int         src, dst, occ, exp_act;
    logic       acc, drn;
    logic [3:0] sv;

    initial begin
        // reset
        #2 areset = 1'b1;
        repeat (10) tick;
        chk("rst_mvalid", 32'(m_tvalid), 0);
        chk("rst_mdata",  32'(m_tdata),  0);
        chk("rst_mlast",  32'(m_tlast),  0);
        chk("rst_sready", 32'(s_tready), 0);
        chk("rst_act",    32'(act_sel),  0);
        areset = 1'b0;
        tick;
        chk("post_rst_sready", 32'(s_tready), 'h0001);
        chk("post_rst_act",    32'(act_sel),  0);

        // streaming on channel 3
        sel = 4'd3;
        m_tready = 1'b1;
        tick;
        chk("str_act", 32'(act_sel), 3);
        for (int k = 0; k < 8; k++) begin
            s_tvalid[3] = 1'b1;
            put(3, 8'(8'h10 + k), k == 7);
            chk("str_rdy", 32'(s_tready), 'h0008);
            tick;
            chk("str_vld",  32'(m_tvalid), 1);
            chk("str_dat",  32'(m_tdata), 32'('h10 + k));
            chk("str_last", 32'(m_tlast), 32'(k == 7));
        end
        s_tvalid[3] = 1'b0;
        tick;
        chk("str_idle", 32'(m_tvalid), 0);

        // select change in the middle of a channel-3 packet
        s_tvalid[1] = 1'b1;
        put(1, 8'h30, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) sel = 4'd1;
            s_tvalid[3] = 1'b1;
            put(3, 8'(8'h20 + k), k == 7);
            chk("mid_rdy", 32'(s_tready), 'h0008);
            tick;
            chk("mid_dat",  32'(m_tdata), 32'('h20 + k));
            chk("mid_last", 32'(m_tlast), 32'(k == 7));
        end
        s_tvalid[3] = 1'b0;
        tick;
        chk("mid_act",   32'(act_sel),  1);
        chk("mid_rdy1",  32'(s_tready), 'h0002);
        chk("mid_gap",   32'(m_tvalid), 0);
        for (int j = 0; j < 4; j++) begin
            put(1, 8'(8'h30 + j), j == 3);
            tick;
            chk("ch1_vld",  32'(m_tvalid), 1);
            chk("ch1_dat",  32'(m_tdata), 32'('h30 + j));
            chk("ch1_last", 32'(m_tlast), 32'(j == 3));
        end
        s_tvalid[1] = 1'b0;
        tick;
        chk("ch1_idle", 32'(m_tvalid), 0);

        // backpressure: 100-beat packet on channel 1, tready pattern 1,0,0,1,0,1
        for (int i = 0; i < 100; i++) din[i] = 8'($urandom_range(0, 255));
        src = 0;
        dst = 0;
        occ = 0;
        for (int cyc = 0; cyc < 600 && dst < 100; cyc++) begin
            m_tready = patt[cyc % 6];
            chk("bp_rdy", 32'(s_tready[1]), 32'(occ < 2));
            chk("bp_vld", 32'(m_tvalid),    32'(occ > 0));
            drn = (occ > 0) && m_tready;
            if (drn) begin
                chk("bp_dat",  32'(m_tdata), 32'(din[dst]));
                chk("bp_last", 32'(m_tlast), 32'(dst == 99));
                dst++;
            end
            acc = (src < 100) && (occ < 2);
            s_tvalid[1] = (src < 100);
            if (src < 100) put(1, din[src], src == 99);
            tick;
            if (acc) src++;
            occ = occ + int'(acc) - int'(drn);
        end
        chk("bp_done", 32'(dst), 100);
        s_tvalid[1] = 1'b0;
        m_tready = 1'b1;
        tick;

        // single-beat packets, sel toggling 2,5 every two cycles
        for (int ch = 0; ch < N; ch++) put(ch, 8'(8'h40 + ch), 1'b1);
        s_tvalid = '1;
        exp_act = 1;
        for (int t = 0; t < 8; t++) begin
            sv  = ((t / 2) % 2 == 1) ? 4'd5 : 4'd2;
            sel = sv;
            tick;
            chk("sb_act", 32'(act_sel),  32'(sv));
            chk("sb_rdy", 32'(s_tready), 32'(1) << sv);
            chk("sb_vld", 32'(m_tvalid), 1);
            chk("sb_dat", 32'(m_tdata),  32'('h40 + exp_act));
            exp_act = int'(sv);
        end
        s_tvalid = '0;
        s_tlast  = '0;
        tick;

        // reset in the middle of a packet with skid full
        sel = 4'd6;
        tick;
        m_tready = 1'b0;
        s_tvalid[6] = 1'b1;
        put(6, 8'h50, 1'b0);
        tick;
        put(6, 8'h51, 1'b0);
        tick;
        chk("rr_full_rdy", 32'(s_tready), 0);
        chk("rr_full_dat", 32'(m_tdata),  'h50);
        chk("rr_full_act", 32'(act_sel),  6);
        areset = 1'b1;
        #1;
        chk("rr_mvalid", 32'(m_tvalid), 0);
        chk("rr_mdata",  32'(m_tdata),  0);
        chk("rr_mlast",  32'(m_tlast),  0);
        chk("rr_sready", 32'(s_tready), 0);
        chk("rr_act",    32'(act_sel),  0);
        s_tvalid = '0;
        sel = 4'd0;
        repeat (3) tick;
        areset = 1'b0;
        tick;
        chk("rr_post_rdy", 32'(s_tready), 'h0001);
        chk("rr_post_vld", 32'(m_tvalid), 0);
        m_tready = 1'b1;
        s_tvalid[0] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            put(0, 8'(8'h60 + j), j == 2);
            tick;
            chk("rr_ch0_vld",  32'(m_tvalid), 1);
            chk("rr_ch0_dat",  32'(m_tdata), 32'('h60 + j));
            chk("rr_ch0_last", 32'(m_tlast), 32'(j == 2));
        end
        s_tvalid[0] = 1'b0;
        tick;
        chk("rr_ch0_idle", 32'(m_tvalid), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
